// File: rtl/mem_pkg.sv
// Shared types and constants for the memory-access stage: operation and
// state encodings, byte-enable masks and small decode helpers.
package mem_pkg;

  typedef enum logic [3:0] {
    MEM_NONE,
    MEM_LB,
    MEM_LH,
    MEM_LW,
    MEM_LBU,
    MEM_LHU,
    MEM_SB,
    MEM_SH,
    MEM_SW
  } mem_op_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } mem_state_t;

  localparam logic [3:0] BE_B = 4'b0001;
  localparam logic [3:0] BE_H = 4'b0011;
  localparam logic [3:0] BE_W = 4'b1111;

  function automatic logic is_store(input mem_op_t op);
    return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
  endfunction

  // Halfword lanes are chosen by addr[1] alone; words ignore the low bits.
  function automatic logic [3:0] be_mask(input mem_op_t op, input logic [1:0] lo);
    logic [3:0] m;
    case (op)
      MEM_LB, MEM_LBU, MEM_SB: m = BE_B << lo;
      MEM_LH, MEM_LHU, MEM_SH: m = BE_H << {lo[1], 1'b0};
      MEM_LW, MEM_SW:          m = BE_W;
      default:                 m = '0;
    endcase
    return m;
  endfunction

  function automatic logic is_misaligned(input mem_op_t op, input logic [1:0] lo);
    logic mis;
    case (op)
      MEM_LH, MEM_LHU, MEM_SH: mis = lo[0];
      MEM_LW, MEM_SW:          mis = (lo != 2'b00);
      default:                 mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/load_align.sv
// Load-data lane selection and sign/zero extension for the memory stage.
module load_align
  import mem_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  mem_op_t         i_op,
  input  logic [1:0]      i_addr_lo,
  input  logic [XLEN-1:0] i_rdata,
  output logic [XLEN-1:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (i_addr_lo)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  always_comb begin
    case (i_op)
      MEM_LB:  o_data = {{(XLEN-8){w_byte[7]}}, w_byte};
      MEM_LBU: o_data = {{(XLEN-8){1'b0}}, w_byte};
      MEM_LH:  o_data = {{(XLEN-16){w_half[15]}}, w_half};
      MEM_LHU: o_data = {{(XLEN-16){1'b0}}, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: issues loads/stores on a req/gnt/rvalid bus and emits
// one writeback pulse per instruction. Optional PAKRV_MEM_MISALIGN_TRAP_EN adds
// the wb_misalign trap output instead of truncating misaligned addresses.
module mem_stage
  import mem_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  mem_op_t           ex_mem_op,
  input  logic [XLEN-1:0]   ex_result,
  input  logic [XLEN-1:0]   ex_store_data,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_rd_we,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [XLEN-1:0]   dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [XLEN-1:0]   dmem_wdata,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic              wb_valid,
  output logic [REG_AW-1:0] wb_rd,
  output logic              wb_rd_we,
`ifdef PAKRV_MEM_MISALIGN_TRAP_EN
  output logic              wb_misalign,
`endif
  output logic [XLEN-1:0]   wb_data
);

  mem_state_t        r_state;
  mem_state_t        w_next_state;

  mem_op_t           r_op;
  logic [1:0]        r_addr_lo;
  logic [REG_AW-1:0] r_rd;
  logic              r_rd_we;

  logic              r_dmem_we;
  logic [XLEN-1:0]   r_dmem_addr;
  logic [3:0]        r_dmem_be;
  logic [XLEN-1:0]   r_dmem_wdata;

  logic              r_wb_valid;
  logic [REG_AW-1:0] r_wb_rd;
  logic              r_wb_rd_we;
  logic [XLEN-1:0]   r_wb_data;

  logic              w_xfer;
  logic              w_is_mem;
  logic              w_misal;
  logic              w_issue;
  logic              w_store_done;
  logic              w_load_done;
  logic [XLEN-1:0]   w_wdata;
  logic [XLEN-1:0]   w_load_data;

  assign w_xfer   = ex_valid && ex_ready;
  assign w_is_mem = (ex_mem_op != MEM_NONE);

`ifdef PAKRV_MEM_MISALIGN_TRAP_EN
  assign w_misal = is_misaligned(ex_mem_op, ex_result[1:0]);
`else
  assign w_misal = 1'b0;
`endif

  assign w_issue      = w_xfer && w_is_mem && !w_misal;
  assign w_store_done = (r_state == REQ) && dmem_gnt && is_store(r_op);
  assign w_load_done  = (r_state == WAIT) && dmem_rvalid;

  always_comb begin
    case (ex_mem_op)
      MEM_SB:  w_wdata = {4{ex_store_data[7:0]}};
      MEM_SH:  w_wdata = {2{ex_store_data[15:0]}};
      default: w_wdata = ex_store_data;
    endcase
  end

  load_align #(
    .XLEN(XLEN)
  ) u_load_align (
    .i_op      (r_op),
    .i_addr_lo (r_addr_lo),
    .i_rdata   (dmem_rdata),
    .o_data    (w_load_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_issue) w_next_state = REQ;
      REQ:     if (dmem_gnt) w_next_state = is_store(r_op) ? IDLE : WAIT;
      WAIT:    if (dmem_rvalid) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Request derives from the state register so reset removes it immediately.
  always_comb begin
    ex_ready = (r_state == IDLE);
    dmem_req = (r_state == REQ);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op         <= MEM_NONE;
      r_addr_lo    <= '0;
      r_rd         <= '0;
      r_rd_we      <= 1'b0;
      r_dmem_we    <= 1'b0;
      r_dmem_addr  <= '0;
      r_dmem_be    <= '0;
      r_dmem_wdata <= '0;
    end else if (w_issue) begin
      r_op         <= ex_mem_op;
      r_addr_lo    <= ex_result[1:0];
      r_rd         <= ex_rd;
      r_rd_we      <= ex_rd_we;
      r_dmem_we    <= is_store(ex_mem_op);
      r_dmem_addr  <= {ex_result[XLEN-1:2], 2'b00};
      r_dmem_be    <= be_mask(ex_mem_op, ex_result[1:0]);
      r_dmem_wdata <= w_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_valid <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_rd_we <= 1'b0;
      r_wb_data  <= '0;
    end else begin
      r_wb_valid <= 1'b0;
      if (w_xfer && !w_is_mem) begin
        r_wb_valid <= 1'b1;
        r_wb_rd    <= ex_rd;
        r_wb_rd_we <= ex_rd_we;
        r_wb_data  <= ex_result;
      end else if (w_xfer && w_misal) begin
        r_wb_valid <= 1'b1;
        r_wb_rd    <= ex_rd;
        r_wb_rd_we <= 1'b0;
        r_wb_data  <= ex_result;
      end else if (w_store_done) begin
        r_wb_valid <= 1'b1;
        r_wb_rd    <= r_rd;
        r_wb_rd_we <= 1'b0;
        r_wb_data  <= '0;
      end else if (w_load_done) begin
        r_wb_valid <= 1'b1;
        r_wb_rd    <= r_rd;
        r_wb_rd_we <= r_rd_we;
        r_wb_data  <= w_load_data;
      end
    end
  end

`ifdef PAKRV_MEM_MISALIGN_TRAP_EN
  logic r_wb_misalign;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_wb_misalign <= 1'b0;
    else        r_wb_misalign <= w_xfer && w_misal;
  end

  assign wb_misalign = r_wb_misalign;
`endif

  assign dmem_we    = r_dmem_we;
  assign dmem_addr  = r_dmem_addr;
  assign dmem_be    = r_dmem_be;
  assign dmem_wdata = r_dmem_wdata;
  assign wb_valid   = r_wb_valid;
  assign wb_rd      = r_wb_rd;
  assign wb_rd_we   = r_wb_rd_we;
  assign wb_data    = r_wb_data;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed cases, reset abort, then random traffic.
module tb_mem_stage;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid;
  logic        ex_ready;
  mem_op_t     ex_mem_op;
  logic [31:0] ex_result;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_rd;
  logic        ex_rd_we;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        wb_rd_we;
  logic [31:0] wb_data;
`ifdef PAKRV_MEM_MISALIGN_TRAP_EN
  logic        wb_misalign;
`endif

  always #5 clk = ~clk;

  mem_stage #(.XLEN(32), .REG_AW(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_mem_op(ex_mem_op),
    .ex_result(ex_result), .ex_store_data(ex_store_data),
    .ex_rd(ex_rd), .ex_rd_we(ex_rd_we),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_rd_we(wb_rd_we),
`ifdef PAKRV_MEM_MISALIGN_TRAP_EN
    .wb_misalign(wb_misalign),
`endif
    .wb_data(wb_data)
  );

  typedef struct {
    logic [4:0]  rd;
    logic        rd_we;
    logic [31:0] data;
    logic        mis;
  } wb_exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rword;
  } bus_exp_t;

  wb_exp_t  q_wb[$];
  bus_exp_t q_bus[$];
  int checks = 0;
  int errors = 0;
  int gnt_dly = -1;
  int rv_dly = -1;
  bit resp_en = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: access width in bytes and byte offset inside the word.
  function automatic int width_of(input mem_op_t op);
    case (op)
      MEM_LB, MEM_LBU, MEM_SB: return 1;
      MEM_LH, MEM_LHU, MEM_SH: return 2;
      MEM_LW, MEM_SW:          return 4;
      default:                 return 0;
    endcase
  endfunction

  function automatic int offset_of(input int w, input logic [31:0] addr);
    int a;
    a = int'(addr % 4);
    if (w == 4) return 0;
    if (w == 2) return (a / 2) * 2;
    return a;
  endfunction

  function automatic bit model_misaligned(input int w, input logic [31:0] addr);
`ifdef PAKRV_MEM_MISALIGN_TRAP_EN
    return (w > 1) && ((addr % w) != 0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic issue(input mem_op_t op, input logic [31:0] addr, input logic [31:0] data,
                       input logic [4:0] rd, input logic rd_we, input logic [31:0] rword);
    int w, off, n;
    wb_exp_t e;
    bus_exp_t b;
    logic [31:0] mask, val;
    bit st;
    n = 0;
    while (!ex_ready) begin
      @(negedge clk);
      n++;
      if (n > 200) begin
        chk("issue_timeout", 32'(ex_ready), 32'd1);
        return;
      end
    end
    w  = width_of(op);
    st = (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    e.rd = rd;
    e.mis = 1'b0;
    if (w == 0) begin
      e.rd_we = rd_we;
      e.data  = addr;
    end else if (model_misaligned(w, addr)) begin
      e.rd_we = 1'b0;
      e.data  = addr;
      e.mis   = 1'b1;
    end else begin
      off     = offset_of(w, addr);
      b.we    = st;
      b.addr  = addr & 32'hFFFF_FFFC;
      b.be    = 4'(((1 << w) - 1) << off);
      for (int i = 0; i < 4; i++) b.wdata[8*i +: 8] = data[8*(i % w) +: 8];
      b.rword = rword;
      q_bus.push_back(b);
      if (st) begin
        e.rd_we = 1'b0;
        e.data  = '0;
      end else begin
        mask = (w == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * w)) - 32'd1);
        val  = (rword >> (8 * off)) & mask;
        if ((op == MEM_LB || op == MEM_LH) && val[8*w-1]) val = val | ~mask;
        e.rd_we = rd_we;
        e.data  = val;
      end
    end
    q_wb.push_back(e);
    ex_valid = 1'b1;
    ex_mem_op = op;
    ex_result = addr;
    ex_store_data = data;
    ex_rd = rd;
    ex_rd_we = rd_we;
    @(negedge clk);
    ex_valid = 1'b0;
    ex_mem_op = mem_op_t'($urandom_range(0, 8));
    ex_result = $urandom;
  endtask

  // Bus slave: grants and returns read data, checking the request it sees.
  initial begin : responder
    bus_exp_t rb;
    int d;
    dmem_gnt = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (resp_en && rst_n && dmem_req) begin
        if (q_bus.size() == 0) begin
          chk("unexpected_req", 32'(dmem_req), 32'd0);
        end else begin
          rb = q_bus.pop_front();
          d = (gnt_dly >= 0) ? gnt_dly : int'($urandom_range(0, 3));
          repeat (d) begin
            chk("req_held", 32'(dmem_req), 32'd1);
            chk("ready_busy", 32'(ex_ready), 32'd0);
            @(negedge clk);
          end
          chk("bus_we", 32'(dmem_we), 32'(rb.we));
          chk("bus_addr", dmem_addr, rb.addr);
          chk("bus_be", 32'(dmem_be), 32'(rb.be));
          if (rb.we) chk("bus_wdata", dmem_wdata, rb.wdata);
          dmem_gnt = 1'b1;
          @(negedge clk);
          dmem_gnt = 1'b0;
          if (!rb.we) begin
            d = (rv_dly >= 0) ? rv_dly : int'($urandom_range(0, 3));
            repeat (d) begin
              chk("req_low_wait", 32'(dmem_req), 32'd0);
              dmem_rdata = $urandom;
              @(negedge clk);
            end
            dmem_rvalid = 1'b1;
            dmem_rdata = rb.rword;
            @(negedge clk);
            dmem_rvalid = 1'b0;
            dmem_rdata = $urandom;
          end
        end
      end
    end
  end

  wb_exp_t me;
  always @(negedge clk) begin
    if (rst_n && wb_valid) begin
      if (q_wb.size() == 0) begin
        chk("wb_unexpected", 32'(wb_valid), 32'd0);
      end else begin
        me = q_wb.pop_front();
        chk("wb_data", wb_data, me.data);
        chk("wb_rd_we", 32'(wb_rd_we), 32'(me.rd_we));
        if (me.rd_we) chk("wb_rd", 32'(wb_rd), 32'(me.rd));
`ifdef PAKRV_MEM_MISALIGN_TRAP_EN
        chk("wb_misalign", 32'(wb_misalign), 32'(me.mis));
`endif
      end
    end
  end

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((q_wb.size() != 0 || !ex_ready) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_wb_empty"}, 32'(q_wb.size()), 32'd0);
  endtask

  initial begin : stim
    int n;
    ex_valid = 1'b0;
    ex_mem_op = MEM_NONE;
    ex_result = '0;
    ex_store_data = '0;
    ex_rd = '0;
    ex_rd_we = 1'b0;

    #3;
    chk("rst_ex_ready", 32'(ex_ready), 32'd1);
    chk("rst_dmem_req", 32'(dmem_req), 32'd0);
    chk("rst_dmem_we", 32'(dmem_we), 32'd0);
    chk("rst_dmem_addr", dmem_addr, 32'd0);
    chk("rst_dmem_be", 32'(dmem_be), 32'd0);
    chk("rst_dmem_wdata", dmem_wdata, 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_rd", 32'(wb_rd), 32'd0);
    chk("rst_wb_rd_we", 32'(wb_rd_we), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
`ifdef PAKRV_MEM_MISALIGN_TRAP_EN
    chk("rst_wb_misalign", 32'(wb_misalign), 32'd0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    issue(MEM_NONE, 32'h0000_1234, 32'h0, 5'd5, 1'b1, 32'h0);
    chk("none_ready_stays", 32'(ex_ready), 32'd1);

    gnt_dly = 3;
    rv_dly = 1;
    issue(MEM_SB, 32'h0000_1003, 32'h0000_00AB, 5'd7, 1'b1, 32'h0);
    gnt_dly = 0;
    issue(MEM_LB, 32'h0000_2001, 32'h0, 5'd8, 1'b1, 32'h0000_8000);
    issue(MEM_LBU, 32'h0000_2001, 32'h0, 5'd9, 1'b1, 32'h0000_8000);
    issue(MEM_LH, 32'h0000_2002, 32'h0, 5'd10, 1'b1, 32'h8001_0000);
    issue(MEM_LW, 32'h0000_2000, 32'h0, 5'd11, 1'b1, 32'hDEAD_BEEF);
    drain("directed");

    resp_en = 1'b0;
    issue(MEM_LW, 32'h0000_4000, 32'h0, 5'd3, 1'b1, 32'h1111_2222);
    n = 0;
    while (!dmem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("abort_req_seen", 32'(dmem_req), 32'd1);
    dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("abort_req_low", 32'(dmem_req), 32'd0);
    chk("abort_wb_low", 32'(wb_valid), 32'd0);
    chk("abort_ready", 32'(ex_ready), 32'd1);
    q_wb.delete();
    q_bus.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    dmem_rvalid = 1'b1;
    dmem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    dmem_rvalid = 1'b0;
    repeat (3) begin
      chk("abort_no_wb", 32'(wb_valid), 32'd0);
      chk("abort_idle_ready", 32'(ex_ready), 32'd1);
      @(negedge clk);
    end
    resp_en = 1'b1;

    gnt_dly = -1;
    rv_dly = -1;
    issue(MEM_LW, 32'h0000_3002, 32'h0, 5'd9, 1'b1, 32'h5555_AAAA);
`ifdef PAKRV_MEM_MISALIGN_TRAP_EN
    chk("misalign_no_req", 32'(dmem_req), 32'd0);
`endif
    drain("misalign");

    for (int i = 0; i < 200; i++) begin
      issue(mem_op_t'($urandom_range(0, 8)), $urandom, $urandom,
            5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain("random");
    chk("bus_q_empty", 32'(q_bus.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage directly downstream of the execute stage.
- Consumes the execute-stage result (ALU result or effective address) plus store data, and performs loads/stores over a req/gnt/rvalid data-memory bus.
- Aligns and sign/zero-extends load data.
- Presents one result per instruction to writeback; back-pressures execute while a memory access is outstanding.

Parameters:
- XLEN, 32, data/address width (only 32 supported)
- REG_AW, 5, register-index width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ex_valid  in  1  execute stage presents an instruction
- ex_ready  out  1  stage accepts instruction this cycle
- ex_mem_op  in  mem_op_t  MEM_NONE/LB/LH/LW/LBU/LHU/SB/SH/SW
- ex_result  in  XLEN  ALU result; effective address for memory ops
- ex_store_data  in  XLEN  rs2 value for stores
- ex_rd  in  REG_AW  destination register
- ex_rd_we  in  1  destination write enable
- dmem_req  out  1  bus request
- dmem_we  out  1  1 = store
- dmem_addr  out  XLEN  word-aligned address
- dmem_be  out  4  byte enables
- dmem_wdata  out  XLEN  lane-replicated store data
- dmem_gnt  in  1  request accepted
- dmem_rvalid  in  1  load data valid
- dmem_rdata  in  XLEN  load data
- wb_valid  out  1  one-cycle result pulse to writeback
- wb_rd  out  REG_AW  destination
- wb_rd_we  out  1  write enable (0 for stores)
- wb_data  out  XLEN  result

Behaviour:
- Reset (async, rst_n=0): state IDLE; outputs ex_ready=1, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_be=0, dmem_wdata=0, wb_valid=0, wb_rd=0, wb_rd_we=0, wb_data=0. Applies mid-transaction: dmem_req drops immediately; a later dmem_rvalid for the aborted load is ignored.
- FSM states: IDLE, REQ, WAIT. ex_ready=1 only in IDLE; transfer occurs when ex_valid&&ex_ready.
- IDLE, transfer with MEM_NONE: next cycle wb_valid=1, wb_data=ex_result, wb_rd/wb_rd_we copied. Stay IDLE. Latency 1.
- IDLE, transfer with memory op:
  - Capture op, low address bits, rd and rd_we into holding registers; go to REQ.
  - Registered bus outputs:
    - dmem_addr = {addr[31:2],2'b00}.
    - dmem_be: SB = 4'b0001<<addr[1:0]; SH = 4'b0011<<{addr[1],1'b0}; SW = 4'b1111; loads use the same mask for their width.
    - dmem_wdata: SB = {4{data[7:0]}}; SH = {2{data[15:0]}}; SW = data.
- REQ: dmem_req=1; all bus outputs held stable until dmem_gnt.
  - Store + gnt: dmem_req=0 next cycle; wb_valid pulse with wb_rd_we=0, wb_data=0; go to IDLE.
  - Load + gnt: go to WAIT.
- WAIT: dmem_req=0.
  - On dmem_rvalid: select lane by captured addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
  - Next cycle: wb_valid=1, wb_data = extended value, wb_rd_we = captured rd_we; go to IDLE.
  - dmem_rvalid in IDLE or REQ is ignored.
- Latency: load ≥ 3 cycles from transfer (1 to REQ, ≥1 for gnt, ≥1 for rvalid). Store ≥ 2 cycles.
- No new transfer is accepted before the current result has pulsed on wb_valid. Writeback never stalls.
- Misaligned addresses (no macro): low bits ignored per width; LH/SH use addr[1] only, LW/SW ignore addr[1:0].
- wb_valid is exactly one cycle per accepted instruction.

Optional Feature:
- Macro: PAKRV_MEM_MISALIGN_TRAP_EN.
- Defined:
  - Adds output port wb_misalign (1).
  - A transfer is misaligned when it is LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0.
  - Misaligned transfers issue no bus request. Next cycle: wb_valid=1, wb_misalign=1, wb_rd_we=0, wb_data = faulting address. State stays IDLE.
  - wb_misalign resets to 0 and equals 0 on all other wb_valid pulses.
- Undefined: port absent; alignment handled by truncation as above.

Decomposition:
- mem_pkg holds:
  - mem_op_t enum
  - state enum mem_state_t
  - byte-enable constants BE_B/BE_H/BE_W
- Sub-module load_align: combinational lane select plus sign/zero extension from (op, addr[1:0], rdata).

Test Plan:
- MEM_NONE, ex_result=0x0000_1234, rd=5, rd_we=1 -> next cycle wb_valid=1, wb_data=0x1234, wb_rd=5, ex_ready stays 1.
- SB addr 0x1003, data 0xAB, gnt delayed 3 cycles -> dmem_req held 3+ cycles, dmem_addr=0x1000, be=4'b1000, wdata=0xABABABAB; then wb_valid with wb_rd_we=0; ex_ready=0 throughout.
- LB addr 0x2001, rdata 0x0000_8000 -> wb_data=0xFFFF_FF80. LBU with the same inputs -> 0x0000_0080.
- LH addr 0x2002, rdata 0x8001_0000 -> be=4'b1100, wb_data=0xFFFF_8001. LW with rdata 0xDEADBEEF -> 0xDEADBEEF.
- Load in WAIT, rst_n pulsed low -> dmem_req=0, wb_valid=0 immediately. Subsequent rvalid -> no wb_valid; ex_ready=1.
- With PAKRV_MEM_MISALIGN_TRAP_EN: LW addr 0x3002 -> no dmem_req, wb_valid=1, wb_misalign=1, wb_data=0x3002.
